sha256_msg_feeder: RTL
======================

Name: sha256_msg_feeder

Overview:
Producer-side front end for the SHA-256 core. Accepts a message as a stream of big-endian 32-bit words and applies FIPS 180-4 padding (0x80 marker, zero fill, 64-bit bit length). Emits successive 512-bit blocks with a start pulse to the core, chains each block's result into the next block's initial hash, and presents the final 256-bit digest.

Parameters:
IV, 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19, initial hash H0..H7, H0 in MSBs
DONE_GUARD, 2, cycles after blk_start during which core_done is ignored (masks a stale done level)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
in_valid  in  1  input word valid
in_ready  out  1  feeder accepts a word this cycle
in_data  in  32  message word; byte 0 in [31:24]
in_last  in  1  final word of the message
in_bytes  in  3  valid bytes in a last word, 0..4, left-justified; ignored unless in_last
blk_w  out  512  block words w0..w15; w0 in [511:480]
blk_hash  out  256  initial hash for the core, A_i..H_i; A_i in MSBs
blk_start  out  1  one-cycle pulse: blk_w/blk_hash are valid
core_done  in  1  core completion level
core_result  in  256  core output: initial hash plus working variables
digest  out  256  final message digest
digest_valid  out  1  digest valid; held until the next message's first accepted word
busy  out  1  high from first accepted word until digest_valid rises

Behaviour:
- Reset values: all outputs 0; blk_hash = IV; state IDLE; word index 0; bit counter 0.
- States: IDLE, FILL, PAD, START, WAIT, FINAL.
- IDLE/FILL:
  - in_ready = 1 while word index < 16.
  - A handshake (in_valid & in_ready) stores in_data at w[index] and increments index.
  - First accepted word of a message: clears digest_valid, sets busy, loads chain hash = IV.
- Non-last word: bitcount += 32.
- Last word, n = in_bytes:
  - bitcount += 8n.
  - Bytes n..3 of that word are zeroed.
  - If n < 4, byte n = 0x80 in the same word.
  - If n = 4, a 0x80000000 word is appended at the next index (marker pending, inserted in PAD).
  - n = 0: the word holds only the marker 0x80000000.
  - Go to PAD.
- Index reaches 16 with no last word: go to START (full data block).
- PAD: one word per cycle.
  - Insert the pending marker, then zero words up to index 13.
  - Words 14/15 = bitcount[63:32], bitcount[31:0].
  - If the marker lands at index 14 or 15: fill zeros to 15, go to START, and set flag len_pending. The following block is all zeros plus the length.
- START:
  - Drive blk_hash = chain hash and blk_start = 1 for exactly one cycle.
  - blk_w is stable from START until the capture in WAIT.
- WAIT:
  - core_done is ignored for DONE_GUARD cycles after START.
  - Then the first cycle with core_done = 1: chain hash <= core_result and index <= 0.
  - Next state:
    - Message not yet terminated: FILL.
    - len_pending: PAD with an empty block (w0..w13 = 0, length in 14/15); clears len_pending.
    - Padded block done: FINAL.
- FINAL: digest <= chain hash; digest_valid = 1, busy = 0; go to IDLE. Latency from core_done capture to digest_valid is 1 cycle.
- in_ready = 0 in PAD/START/WAIT/FINAL. in_valid while in_ready = 0 is held upstream (standard valid/ready rule: data stable until accepted).
- Bit counter is 64-bit and wraps modulo 2^64, per spec modulo rule.
- Simultaneous: a last word accepted at index 15 with n = 4 means the marker overflows to the next block. That block = marker word + zeros + length (no third block).
- Reset deasserted mid-message: all state cleared. An in-flight core computation is abandoned; a later core_done is ignored (state IDLE).
- A core_done already high at blk_start time (stale level) is masked by DONE_GUARD.

Test Plan:
1. Message "abc": single word 0x61626300, in_last, in_bytes = 3 -> one blk_start; w0 = 0x61626380, w15 = 0x18; with a reference core, digest = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
2. Empty message: one word, in_last, in_bytes = 0 -> w0 = 0x80000000, w15 = 0; digest = e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
3. 56-byte "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" (14 words, last in_bytes = 4) -> two blk_starts:
   - Block 1: w14 = 0x80000000, w15 = 0.
   - Block 2: w0..w14 = 0, w15 = 0x1c0.
   - Second blk_hash = first core_result.
   - digest = 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
4. 55-byte message (last in_bytes = 3) -> exactly one block; w13 ends in 0x80, w15 = 0x1b8.
5. Backpressure/guard: hold core_done = 1 continuously -> no capture during the DONE_GUARD cycles after blk_start; in_ready = 0 throughout WAIT; in_valid bubbles during FILL do not corrupt word order.
6. Reset asserted during WAIT of a 2-block message -> all outputs 0, blk_hash = IV; a new "abc" afterward produces the correct digest.

Source files
------------

// File: rtl/sha256_msg_feeder_if.sv
// Message word stream into the SHA-256 feeder: big-endian 32-bit words with a
// valid/ready handshake, an end-of-message flag and the byte count of the last word.
`timescale 1ns/1ps
interface sha256_msg_feeder_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic [2:0]  in_bytes;

    modport master (output in_valid, in_data, in_last, in_bytes, input in_ready);
    modport slave  (input in_valid, in_data, in_last, in_bytes, output in_ready);
endinterface

// File: rtl/sha256_msg_feeder.sv
// Pads a word-serial message into 512-bit SHA-256 blocks, sequences the core one
// block at a time and chains each block result into the next initial hash.
`timescale 1ns/1ps
module sha256_msg_feeder #(
    parameter logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19,
    parameter int DONE_GUARD = 2
) (
    input  logic               clk,
    input  logic               reset,
    sha256_msg_feeder_if.slave msg,
    output logic [511:0]       blk_w,
    output logic [255:0]       blk_hash,
    output logic               blk_start,
    input  logic               core_done,
    input  logic [255:0]       core_result,
    output logic [255:0]       digest,
    output logic               digest_valid,
    output logic               busy
);
    localparam int GW = (DONE_GUARD < 2) ? 1 : $clog2(DONE_GUARD + 1);

    typedef enum logic [2:0] {IDLE, FILL, PAD, START, WAIT, FINAL} state_t;

    state_t        state_q, state_d;
    logic [4:0]    idx_q, idx_d;
    logic [63:0]   bitcnt_q, bitcnt_d;
    logic [255:0]  chain_q, chain_d;
    logic [255:0]  blk_hash_q, blk_hash_d;
    logic [255:0]  digest_q, digest_d;
    logic          digest_valid_q, digest_valid_d;
    logic          busy_q, busy_d;
    logic          in_ready_q, in_ready_d;
    logic          pad_q, pad_d;            // message terminated, padding in progress
    logic          mark_q, mark_d;          // 0x80 marker word still to be placed
    logic          hi_q, hi_d;              // length high word already at index 14
    logic          len_done_q, len_done_d;  // length written: this is the last block
    logic [GW-1:0] guard_q, guard_d;
    logic [31:0]   w_q [16];
    logic          w_we;
    logic [31:0]   w_wdata;
    logic [2:0]    n_bytes;
    logic [31:0]   last_word;
    logic [63:0]   bit_base;

    assign n_bytes = (msg.in_bytes > 3'd4) ? 3'd4 : msg.in_bytes;

    // Last word: keep bytes below n, put the marker at byte n, zero the rest.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign last_word[31-8*gi -: 8] = (n_bytes > 3'(gi))  ? msg.in_data[31-8*gi -: 8] :
                                         (n_bytes == 3'(gi)) ? 8'h80 : 8'h00;
    end

    for (genvar gi = 0; gi < 16; gi++) begin : g_blk
        assign blk_w[511-32*gi -: 32] = w_q[gi];
    end

    assign blk_hash     = blk_hash_q;
    assign blk_start    = (state_q == START);
    assign digest       = digest_q;
    assign digest_valid = digest_valid_q;
    assign busy         = busy_q;
    assign msg.in_ready = in_ready_q;

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        bitcnt_d       = bitcnt_q;
        chain_d        = chain_q;
        blk_hash_d     = blk_hash_q;
        digest_d       = digest_q;
        digest_valid_d = digest_valid_q;
        busy_d         = busy_q;
        pad_d          = pad_q;
        mark_d         = mark_q;
        hi_d           = hi_q;
        len_done_d     = len_done_q;
        guard_d        = guard_q;
        w_we           = 1'b0;
        w_wdata        = '0;
        bit_base       = bitcnt_q;

        case (state_q)
            IDLE, FILL: begin
                if (msg.in_valid && in_ready_q) begin
                    w_we  = 1'b1;
                    idx_d = idx_q + 5'd1;
                    if (state_q == IDLE) begin
                        chain_d        = IV;
                        digest_valid_d = 1'b0;
                        busy_d         = 1'b1;
                        bit_base       = '0;
                        pad_d          = 1'b0;
                        mark_d         = 1'b0;
                        hi_d           = 1'b0;
                        len_done_d     = 1'b0;
                        state_d        = FILL;
                    end
                    if (msg.in_last) begin
                        w_wdata  = last_word;
                        bitcnt_d = bit_base + {58'd0, n_bytes, 3'd0};
                        mark_d   = (n_bytes == 3'd4);
                        pad_d    = 1'b1;
                        state_d  = PAD;
                    end else begin
                        w_wdata  = msg.in_data;
                        bitcnt_d = bit_base + 64'd32;
                        if (idx_q == 5'd15) state_d = START;
                    end
                end
            end
            PAD: begin
                if (idx_q[4]) begin
                    state_d = START;
                end else if (mark_q) begin
                    w_we    = 1'b1;
                    w_wdata = 32'h8000_0000;
                    mark_d  = 1'b0;
                    idx_d   = idx_q + 5'd1;
                end else if (idx_q < 5'd14) begin
                    w_we  = 1'b1;
                    idx_d = idx_q + 5'd1;
                end else if (idx_q == 5'd14) begin
                    w_we    = 1'b1;
                    w_wdata = bitcnt_q[63:32];
                    hi_d    = 1'b1;
                    idx_d   = idx_q + 5'd1;
                end else begin
                    // Index 15 without the high length word means the marker landed
                    // too late: close this block with zero, length follows next block.
                    w_we    = 1'b1;
                    idx_d   = idx_q + 5'd1;
                    state_d = START;
                    if (hi_q) begin
                        w_wdata    = bitcnt_q[31:0];
                        hi_d       = 1'b0;
                        len_done_d = 1'b1;
                    end
                end
            end
            START: begin
                guard_d = GW'(DONE_GUARD);
                state_d = WAIT;
            end
            WAIT: begin
                if (guard_q != '0) begin
                    guard_d = guard_q - 1'b1;
                end else if (core_done) begin
                    chain_d = core_result;
                    idx_d   = '0;
                    if (!pad_q) begin
                        state_d = FILL;
                    end else if (!len_done_q) begin
                        state_d = PAD;
                    end else begin
                        digest_d       = core_result;
                        digest_valid_d = 1'b1;
                        busy_d         = 1'b0;
                        state_d        = FINAL;
                    end
                end
            end
            FINAL:   state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (state_d == START) blk_hash_d = chain_d;
        in_ready_d = ((state_d == IDLE) || (state_d == FILL)) && !idx_d[4];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            bitcnt_q       <= '0;
            chain_q        <= IV;
            blk_hash_q     <= IV;
            digest_q       <= '0;
            digest_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            in_ready_q     <= 1'b0;
            pad_q          <= 1'b0;
            mark_q         <= 1'b0;
            hi_q           <= 1'b0;
            len_done_q     <= 1'b0;
            guard_q        <= '0;
            for (int i = 0; i < 16; i++) w_q[i] <= '0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            bitcnt_q       <= bitcnt_d;
            chain_q        <= chain_d;
            blk_hash_q     <= blk_hash_d;
            digest_q       <= digest_d;
            digest_valid_q <= digest_valid_d;
            busy_q         <= busy_d;
            in_ready_q     <= in_ready_d;
            pad_q          <= pad_d;
            mark_q         <= mark_d;
            hi_q           <= hi_d;
            len_done_q     <= len_done_d;
            guard_q        <= guard_d;
            if (w_we) w_q[idx_q[3:0]] <= w_wdata;
        end
    end
endmodule
